// File: rtl/img_frame_writer.sv
// -----------------------------------------------------------------------------
// img_frame_writer
//   Consumer end of the selected video stream. Pairs of RGB565 pixels are
//   packed into 32-bit words (first pixel in [15:0], second in [31:16]). The
//   words are buffered in a show-ahead FIFO of depth 2*BURST_LEN. The FIFO is
//   drained to the frame-buffer memory controller as fixed-length write bursts
//   using a request/acknowledge handshake. The block also tracks frame
//   boundaries, the write address, FIFO overflow and the completed bank.
//
// Optional feature macro: IMG_WR_PINGPONG_EN
//   defined   : two frame buffers, at FRAME_BASE and FRAME_BASE+FRAME_WORDS.
//               The write bank toggles on each completed frame.
//   undefined : single buffer at FRAME_BASE; rd_bank is tied to 0.
//
// Ports:
//   clk          pixel/system clock
//   rst          asynchronous reset, active-low
//   img_vs       vertical sync (active-high); a rising edge starts a new frame
//   img_de       data enable (active video)
//   img_data_en  pixel strobe
//   img_data     RGB565 pixel
//   wr_req       burst request to the memory controller
//   wr_ack       one-cycle grant of the current request
//   wr_addr      burst start word address; stable while wr_req=1
//   wr_en        write-data strobe (one FIFO pop per strobe)
//   wr_data      write word (FIFO head)
//   wr_rdy       controller accepts a word this cycle
//   frame_done   one-cycle pulse after the last burst of a frame
//   ovf          sticky FIFO overflow flag, cleared at frame start
//   rd_bank      bank holding the last complete frame
// -----------------------------------------------------------------------------
module img_frame_writer #(
  parameter int                H_ACT      = 640,
  parameter int                V_ACT      = 480,
  parameter int                BURST_LEN  = 64,
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] FRAME_BASE = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_vs,
  input  logic              img_de,
  input  logic              img_data_en,
  input  logic [15:0]       img_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  input  logic              wr_rdy,
  output logic              frame_done,
  output logic              ovf,
  output logic              rd_bank
);

  localparam int FRAME_WORDS = (H_ACT * V_ACT) / 2;
  localparam int DEPTH       = 2 * BURST_LEN;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int FW_W        = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W      = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C     = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE_C   = PTR_W'(1);
  localparam logic [FW_W-1:0]   FW_C        = FW_W'(FRAME_WORDS);
  localparam logic [FW_W-1:0]   FW_BL_C     = FW_W'(BURST_LEN);
  localparam logic [FW_W-1:0]   FW_ONE_C    = FW_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST_C = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE_C  = BEAT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP_C = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic               vs_d_r;
  logic               vs_pend_r;
  logic               vs_rise_s;
  logic               service_s;

  logic               half_r;
  logic [15:0]        lo_r;
  logic [FW_W-1:0]    in_cnt_r;
  logic               accept_s;
  logic               push_s;
  logic               push_ok_s;
  logic               full_s;

  logic [31:0]        mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   fill_r;

  logic [BEAT_W-1:0]  beat_r;
  logic [FW_W-1:0]    wcnt_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  base_s;
  logic               done_hit_s;
  logic               frame_done_r;
  logic               ovf_r;

  // A new frame is only started from IDLE so an in-flight burst always finishes.
  assign vs_rise_s  = img_vs & ~vs_d_r;
  assign service_s  = (state_r == ST_IDLE) & vs_pend_r;

  // Pixels are dropped while a frame start is pending.
  assign accept_s   = img_de & img_data_en & ~vs_pend_r;
  assign push_s     = accept_s & half_r & (in_cnt_r != FW_C);
  assign full_s     = (fill_r == DEPTH_C);
  assign push_ok_s  = push_s & ~full_s;

  assign done_hit_s = (state_r == ST_DONE) & ((wcnt_r + FW_BL_C) == FW_C);

  assign wr_req     = (state_r == ST_REQ);
  // Entry needs fill >= BURST_LEN, so the FIFO cannot run dry during a burst.
  assign wr_en      = (state_r == ST_BURST) & wr_rdy;
  assign wr_data    = mem_r[rd_ptr_r];
  assign wr_addr    = addr_r;
  assign frame_done = frame_done_r;
  assign ovf        = ovf_r;

`ifdef IMG_WR_PINGPONG_EN
  localparam logic [ADDR_W-1:0] BANK1_BASE_C = FRAME_BASE + ADDR_W'(FRAME_WORDS);

  logic wbank_r;
  logic rd_bank_r;

  assign base_s  = wbank_r ? BANK1_BASE_C : FRAME_BASE;
  assign rd_bank = rd_bank_r;

  // Bank bookkeeping: completed frame becomes readable, writer moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank_r   <= 1'b0;
      rd_bank_r <= 1'b0;
    end else if (done_hit_s) begin
      rd_bank_r <= wbank_r;
      wbank_r   <= ~wbank_r;
    end else begin
      rd_bank_r <= rd_bank_r;
      wbank_r   <= wbank_r;
    end
  end
`else
  assign base_s  = FRAME_BASE;
  assign rd_bank = 1'b0;
`endif

  // Frame-start detection: registered vs edge raises a pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_d_r    <= 1'b0;
      vs_pend_r <= 1'b0;
    end else begin
      vs_d_r <= img_vs;
      if (vs_rise_s) begin
        vs_pend_r <= 1'b1;
      end else if (service_s) begin
        vs_pend_r <= 1'b0;
      end else begin
        vs_pend_r <= vs_pend_r;
      end
    end
  end

  // Packer, FIFO pointers/fill and per-frame packed-word count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_r   <= 1'b0;
      lo_r     <= 16'h0000;
      in_cnt_r <= {FW_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {CNT_W{1'b0}};
    end else if (service_s) begin
      // Flush: an odd leftover pixel and all buffered words are discarded.
      half_r   <= 1'b0;
      in_cnt_r <= {FW_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        half_r <= ~half_r;
        if (!half_r) begin
          lo_r <= img_data;
        end
      end
      if (push_s) begin
        in_cnt_r <= in_cnt_r + FW_ONE_C;
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (wr_en) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_ok_s, wr_en})
        2'b10:   fill_r <= fill_r + CNT_ONE_C;
        2'b01:   fill_r <= fill_r - CNT_ONE_C;
        default: fill_r <= fill_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because fill gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {img_data, lo_r};
    end
  end

  // Overflow flag: sticky until the next frame start is serviced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (service_s) begin
      ovf_r <= 1'b0;
    end else if (push_s & full_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!vs_pend_r && (fill_r >= BURST_C)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (wr_ack) begin
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_BURST: begin
        if (wr_en && (beat_r == BEAT_LAST_C)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Beat counter, write address, completed-word count and frame_done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_r       <= {BEAT_W{1'b0}};
      wcnt_r       <= {FW_W{1'b0}};
      addr_r       <= FRAME_BASE;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= done_hit_s;
      if ((state_r == ST_BURST) && wr_en) begin
        beat_r <= (beat_r == BEAT_LAST_C) ? {BEAT_W{1'b0}} : (beat_r + BEAT_ONE_C);
      end
      if (service_s) begin
        wcnt_r <= {FW_W{1'b0}};
        addr_r <= base_s;
      end else if (state_r == ST_DONE) begin
        wcnt_r <= wcnt_r + FW_BL_C;
        addr_r <= addr_r + ADDR_STEP_C;
      end else begin
        wcnt_r <= wcnt_r;
        addr_r <= addr_r;
      end
    end
  end

endmodule

// File: tb/tb_img_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_img_frame_writer
//   Self-checking bench for img_frame_writer with H_ACT=8, V_ACT=4,
//   BURST_LEN=4, FRAME_BASE=0x100 (16 words per frame). A scenario table
//   drives whole frames under different wr_rdy / wr_ack behaviour; hand
//   sequences cover overflow, a frame start during a burst and an odd pixel
//   count before a frame start. Expected words and addresses come from a
//   frame-level model: pixel pairs become words, at most 16 per frame, written
//   as 4-word bursts from the current bank base.
// -----------------------------------------------------------------------------
module tb_img_frame_writer;

  localparam int                H_ACT      = 8;
  localparam int                V_ACT      = 4;
  localparam int                BURST_LEN  = 4;
  localparam int                ADDR_W     = 22;
  localparam logic [ADDR_W-1:0] FRAME_BASE = 22'h000100;
  localparam int                FW         = (H_ACT * V_ACT) / 2;
  localparam int                DEPTH      = 2 * BURST_LEN;
`ifdef IMG_WR_PINGPONG_EN
  localparam bit                PP         = 1'b1;
`else
  localparam bit                PP         = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              img_vs;
  logic              img_de;
  logic              img_data_en;
  logic [15:0]       img_data;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              wr_rdy;
  logic              frame_done;
  logic              ovf;
  logic              rd_bank;

  img_frame_writer #(
    .H_ACT     (H_ACT),
    .V_ACT     (V_ACT),
    .BURST_LEN (BURST_LEN),
    .ADDR_W    (ADDR_W),
    .FRAME_BASE(FRAME_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .img_vs     (img_vs),
    .img_de     (img_de),
    .img_data_en(img_data_en),
    .img_data   (img_data),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_rdy     (wr_rdy),
    .frame_done (frame_done),
    .ovf        (ovf),
    .rd_bank    (rd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int rdy_mode    = 0;   // 0 always 1, 1 toggle, 2 random (never low twice), 3 held low
  bit ack_en      = 1'b1;
  int ack_dly_max = 0;

  logic [15:0]       pix_q[$];
  logic [31:0]       exp_words[$];
  logic [ADDR_W-1:0] exp_addrs[$];
  logic [31:0]       obs_words[$];
  logic [ADDR_W-1:0] obs_addrs[$];
  int                burst_cnt[$];
  int                obs_fd[$];
  logic              req_prev = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic              exp_wbank = 1'b0;
  logic              exp_rd_bank = 1'b0;

  typedef struct {
    int rdy_mode;
    int ack_max;
    int gmin;
    int gmax;
    int incr;      // 1: incrementing pixels, 0: random pixels
    int n_pix;
    int exp_fd;
    int exp_ovf;
  } row_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      obs_words.push_back(wr_data);
      if (burst_cnt.size() > 0) burst_cnt[burst_cnt.size()-1] += 1;
      chk("wr_en_without_rdy", 64'(wr_rdy), 64'd1);
    end
    if (wr_req && !req_prev) begin
      obs_addrs.push_back(wr_addr);
      burst_cnt.push_back(0);
      held_addr = wr_addr;
    end else if (wr_req && req_prev) begin
      chk("addr_hold", 64'(wr_addr), 64'(held_addr));
    end
    req_prev = wr_req;
    if (frame_done) obs_fd.push_back(obs_words.size());
  end

  // wr_rdy driver.
  initial begin
    wr_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wr_rdy = 1'b1;
        1:       wr_rdy = ~wr_rdy;
        2:       wr_rdy = (!wr_rdy) ? 1'b1 : 1'($urandom_range(0, 1));
        3:       wr_rdy = 1'b0;
        default: wr_rdy = 1'b1;
      endcase
    end
  end

  // wr_ack responder: one-cycle grant after a (possibly random) delay.
  initial begin
    int d;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req && ack_en) begin
        d = (ack_dly_max > 0) ? $urandom_range(0, ack_dly_max) : 0;
        repeat (d) @(negedge clk);
        @(posedge clk);
        #1 wr_ack = 1'b1;
        @(posedge clk);
        #1 wr_ack = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDR_W-1:0] bank_base();
    return (PP && exp_wbank) ? (FRAME_BASE + ADDR_W'(FW)) : FRAME_BASE;
  endfunction

  task automatic clear_obs();
    obs_words.delete();
    obs_addrs.delete();
    burst_cnt.delete();
    obs_fd.delete();
    exp_words.delete();
    exp_addrs.delete();
  endtask

  task automatic vs_pulse();
    img_de      = 1'b0;
    img_data_en = 1'b0;
    img_vs      = 1'b1;
    step(2);
    img_vs      = 1'b0;
    step(4);
  endtask

  task automatic make_pix(input int n, input int incr, input logic [15:0] offs);
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      pix_q.push_back(incr ? (offs + 16'(i)) : 16'($urandom_range(0, 65535)));
    end
  endtask

  task automatic send_pix(input int gmin, input int gmax);
    img_de = 1'b1;
    foreach (pix_q[i]) begin
      img_data_en = 1'b1;
      img_data    = pix_q[i];
      step(1);
      img_data_en = 1'b0;
      step($urandom_range(gmin, gmax));
    end
    img_de = 1'b0;
  endtask

  // Frame model: pairs -> words, at most FW per frame, at most cap kept.
  task automatic build_exp(input int cap);
    int nb;
    exp_words.delete();
    exp_addrs.delete();
    for (int i = 0; i + 1 < pix_q.size(); i += 2) begin
      if (exp_words.size() < FW && exp_words.size() < cap) exp_words.push_back({pix_q[i+1], pix_q[i]});
    end
    nb = exp_words.size() / BURST_LEN;
    for (int k = 0; k < nb; k++) exp_addrs.push_back(bank_base() + ADDR_W'(k * BURST_LEN));
  endtask

  task automatic wait_and_check(input string tag, input int exp_fd);
    int budget = 3000;
    while ((obs_words.size() < exp_words.size() || obs_fd.size() < exp_fd) && budget > 0) begin
      step(1);
      budget--;
    end
    chk({tag, "_timeout"}, 64'(budget > 0), 64'd1);
    step(12);
    chk({tag, "_nwords"}, 64'(obs_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(obs_words[i]), 64'(exp_words[i]));
    chk({tag, "_nbursts"}, 64'(obs_addrs.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < obs_addrs.size() && i < exp_addrs.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 64'(obs_addrs[i]), 64'(exp_addrs[i]));
    foreach (burst_cnt[i]) chk($sformatf("%s_burstlen%0d", tag, i), 64'(burst_cnt[i]), 64'(BURST_LEN));
    chk({tag, "_nframedone"}, 64'(obs_fd.size()), 64'(exp_fd));
    if (exp_fd == 1 && obs_fd.size() >= 1) chk({tag, "_fd_pos"}, 64'(obs_fd[0]), 64'(FW));
    if (exp_fd == 1 && PP) begin
      exp_rd_bank = exp_wbank;
      exp_wbank   = ~exp_wbank;
    end
    chk({tag, "_rd_bank"}, 64'(rd_bank), 64'(exp_rd_bank));
  endtask

  row_t rows[5];

  initial begin
    rows[0] = '{rdy_mode: 0, ack_max: 0, gmin: 1, gmax: 1, incr: 1, n_pix: 32, exp_fd: 1, exp_ovf: 0};
    rows[1] = '{rdy_mode: 1, ack_max: 0, gmin: 1, gmax: 1, incr: 1, n_pix: 32, exp_fd: 1, exp_ovf: 0};
    rows[2] = '{rdy_mode: 2, ack_max: 3, gmin: 2, gmax: 5, incr: 0, n_pix: 32, exp_fd: 1, exp_ovf: 0};
    rows[3] = '{rdy_mode: 2, ack_max: 2, gmin: 2, gmax: 4, incr: 0, n_pix: 36, exp_fd: 1, exp_ovf: 0};
    rows[4] = '{rdy_mode: 0, ack_max: 1, gmin: 2, gmax: 3, incr: 0, n_pix: 32, exp_fd: 1, exp_ovf: 0};

    rst = 1'b0; img_vs = 1'b0; img_de = 1'b0; img_data_en = 1'b0; img_data = 16'h0000;
    step(3);
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_rd_bank", 64'(rd_bank), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'(FRAME_BASE));
    rst = 1'b1;
    step(3);
    chk("post_rst_wr_req", 64'(wr_req), 64'd0);

    // Table-driven full frames.
    for (int r = 0; r < 5; r++) begin
      clear_obs();
      rdy_mode    = rows[r].rdy_mode;
      ack_dly_max = rows[r].ack_max;
      vs_pulse();
      make_pix(rows[r].n_pix, rows[r].incr, 16'h0000);
      build_exp(FW);
      if (r == 0) chk("first_word_model", 64'(exp_words[0]), 64'h00010000);
      send_pix(rows[r].gmin, rows[r].gmax);
      wait_and_check($sformatf("row%0d", r), rows[r].exp_fd);
      chk($sformatf("row%0d_ovf", r), 64'(ovf), 64'(rows[r].exp_ovf));
    end

    // Overflow: ack withheld while a whole frame arrives.
    clear_obs();
    rdy_mode = 0; ack_dly_max = 0; ack_en = 1'b0;
    vs_pulse();
    make_pix(32, 1, 16'h0100);
    build_exp(DEPTH);
    send_pix(1, 1);
    step(5);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_req_waiting", 64'(wr_req), 64'd1);
    ack_en = 1'b1;
    wait_and_check("ovf", 0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    vs_pulse();
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Frame start while a burst is stalled: burst completes, then flush.
    clear_obs();
    rdy_mode = 3;
    vs_pulse();
    make_pix(12, 0, 16'h0000);
    build_exp(BURST_LEN);
    send_pix(1, 1);
    begin
      int budget = 200;
      while (!(obs_addrs.size() >= 1 && !wr_req) && budget > 0) begin
        step(1);
        budget--;
      end
      chk("midburst_in_burst", 64'(budget > 0), 64'd1);
    end
    img_vs = 1'b1;
    step(2);
    img_vs = 1'b0;
    step(2);
    rdy_mode = 0;
    wait_and_check("midburst", 0);
    clear_obs();
    make_pix(32, 0, 16'h0000);
    build_exp(FW);
    send_pix(1, 2);
    wait_and_check("after_midburst", 1);

    // Odd pixel count followed by a frame start.
    clear_obs();
    vs_pulse();
    make_pix(5, 1, 16'hA000);
    send_pix(1, 1);
    step(5);
    vs_pulse();
    make_pix(32, 1, 16'h5000);
    build_exp(FW);
    send_pix(1, 1);
    wait_and_check("oddpix", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_frame_writer.md
Name: img_frame_writer

Overview:
Consumer end of the selected video stream produced by the image-select stage (img_vs / img_de / img_data_en / img_data). Packs 16-bit RGB565 pixels into 32-bit words and buffers them in an internal FIFO. Drains the FIFO to the frame-buffer memory controller as fixed-length write bursts, using a request/acknowledge handshake. Also tracks frame boundaries, the write address and overflow.

Parameters:
H_ACT, 640, active pixels per line (must be even)
V_ACT, 480, active lines per frame
BURST_LEN, 64, 32-bit words per write burst (power of 2)
ADDR_W, 22, word-address width
FRAME_BASE, 0, word address of frame buffer 0
Derived FRAME_WORDS = H_ACT*V_ACT/2; it must be a multiple of BURST_LEN.

Ports:
clk  in  1  pixel/system clock
rst  in  1  asynchronous reset, active-low
img_vs  in  1  vertical sync, active-high
img_de  in  1  data enable (active video)
img_data_en  in  1  pixel strobe
img_data  in  16  pixel, RGB565
wr_req  out  1  burst request to memory controller
wr_ack  in  1  one-cycle grant of the current request
wr_addr  out  ADDR_W  burst start word address; held stable while wr_req=1
wr_en  out  1  write-data strobe
wr_data  out  32  write word
wr_rdy  in  1  controller can accept a word this cycle
frame_done  out  1  one-cycle pulse when the last burst of a frame completes
ovf  out  1  sticky FIFO overflow flag; cleared when a new frame starts
rd_bank  out  1  bank holding the last complete frame

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, packer empty, address = FRAME_BASE, state IDLE, bank 0.
- Pixel accept: only when img_de=1 and img_data_en=1.
  - First pixel of a pair goes to wr_data[15:0]; second goes to [31:16].
  - A word is pushed on the second pixel.
  - Words beyond FRAME_WORDS in a frame are discarded.
- FIFO: depth 2*BURST_LEN, show-ahead (head visible on wr_data).
  - A push when full drops the word and sets ovf.
- Frame start: a rising edge of img_vs (registered) sets vs_pend.
  - While vs_pend=1, accepted pixels are dropped.
  - vs_pend is serviced only in IDLE: FIFO flushed, packer cleared, frame word count = 0, address = current bank base, ovf cleared, vs_pend cleared.
  - An odd leftover pixel is discarded.
  - A vs edge mid-burst therefore never truncates the burst.
- State machine:
  - IDLE -> REQ when FIFO fill >= BURST_LEN and vs_pend=0. wr_req goes to 1 on the next cycle.
  - REQ: wr_req=1 and wr_addr held until wr_ack=1, then -> BURST. wr_req drops in the same cycle the ack is sampled.
  - BURST: wr_en = wr_rdy, combinational from the FIFO non-empty, guaranteed by the entry check. Each wr_en pops one word. After BURST_LEN pops -> DONE.
  - DONE, one cycle: address += BURST_LEN, frame word count updated.
    - If the count equals FRAME_WORDS: pulse frame_done and update rd_bank.
    - Then -> IDLE.
- wr_ack outside REQ is ignored. wr_rdy low stalls the burst indefinitely, with no timeout.
- Address arithmetic is modulo 2^ADDR_W.
- A simultaneous push and pop in the same cycle leaves fill unchanged.

Optional Feature:
IMG_WR_PINGPONG_EN
- Defined: two buffers, with bases FRAME_BASE and FRAME_BASE+FRAME_WORDS.
  - On frame_done, the write bank toggles and rd_bank is set to the bank just completed.
  - The next frame start uses the new bank base.
- Undefined: single buffer; the base is always FRAME_BASE and rd_bank is tied to 0.

Test Plan (H_ACT=8, V_ACT=4, BURST_LEN=4, FRAME_BASE=0x100; FRAME_WORDS=16):
- Reset, then a vs pulse and one frame of incrementing pixels 0x0000..0x001F, with wr_ack 1 cycle after each wr_req and wr_rdy=1 -> 4 bursts at 0x100, 0x104, 0x108, 0x10C. First word is 0x00010000. One frame_done pulse after the 16th wr_en.
- Same frame, but wr_rdy toggles 1/0 every cycle -> every wr_en coincides with wr_rdy=1. Word order and values are unchanged, and each burst contains exactly 4 wr_en.
- wr_ack withheld for 40 cycles while a whole frame arrives -> FIFO fills to 8 words, ovf=1 and later words are dropped. ovf clears at the next vs once IDLE is reached.
- vs rising edge while in BURST -> the burst completes with 4 words. The flush and address reset happen afterwards, and the next request is at 0x100 (single bank).
- 5 pixels followed by a vs edge -> 2 words pushed and the odd pixel discarded. The new frame's first word is built from fresh pixels only.
- With IMG_WR_PINGPONG_EN, two frames -> frame 1 bursts start at 0x100 and frame 2 bursts at 0x110. rd_bank is 0 after frame 1 and 1 after frame 2. Without the macro, both frames are written at 0x100 and rd_bank stays 0.
